out_sig_compactor: RTL and testbench

- Downstream consumer of the fuzz DUT's wide output bus (out_flat).
- Compacts one output vector per cycle into a MISR signature over a programmed number of cycles, so runs on different simulators compare as a single word instead of a per-cycle text dump.
- Two-stage pipeline: the first stage XOR-folds the wide input to signature width; the second stage updates the MISR.
- Run control by a start/num_cycles handshake and an IDLE/RUN/DONE state machine.

---
 rtl/out_sig_compactor_pkg.sv | 34 +++
 rtl/out_sig_compactor_xor_folder.sv | 31 +++
 rtl/out_sig_compactor.sv | 107 ++++++++++
 tb/tb_out_sig_compactor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/out_sig_compactor_pkg.sv
//==============================================================================
// Module      : sig_pkg
// Description : Shared types, sizing constants and MISR step for the
//               out_sig_compactor signature unit.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package sig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 330;
  localparam int SIG_W_DEF  = 32;
  localparam int NCHUNK     = (DATA_W_DEF + SIG_W_DEF - 1) / SIG_W_DEF;

  // MSB leaves through the shift and re-enters only via the polynomial taps.
  function automatic logic [SIG_W_DEF-1:0] misr_step(
    input logic [SIG_W_DEF-1:0] sig,
    input logic [SIG_W_DEF-1:0] fold,
    input logic [SIG_W_DEF-1:0] poly
  );
    logic [SIG_W_DEF-1:0] fb;
    fb = sig[SIG_W_DEF-1] ? poly : '0;
    return {sig[SIG_W_DEF-2:0], 1'b0} ^ fb ^ fold;
  endfunction

endpackage

`default_nettype wire

// File: rtl/out_sig_compactor_xor_folder.sv
//==============================================================================
// Module      : xor_folder
// Description : Zero-pads a wide vector to whole SIG_W chunks and XORs them.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module xor_folder #(
  parameter int DATA_W = 330,
  parameter int SIG_W  = 32
) (
  input  logic [DATA_W-1:0] data_in,
  output logic [SIG_W-1:0]  fold
);

  localparam int NCH = (DATA_W + SIG_W - 1) / SIG_W;

  logic [NCH*SIG_W-1:0] padded;

  always_comb begin
    padded               = '0;
    padded[DATA_W-1:0]   = data_in;
    fold                 = '0;
    for (int k = 0; k < NCH; k++) begin
      fold = fold ^ padded[k*SIG_W +: SIG_W];
    end
  end

endmodule

`default_nettype wire

// File: rtl/out_sig_compactor.sv
//==============================================================================
// Module      : out_sig_compactor
// Description : Folds one wide output vector per beat and compacts a
//               programmed number of beats into a MISR signature.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module out_sig_compactor
  import sig_pkg::*;
#(
  parameter int               DATA_W = 330,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       num_cycles,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [31:0]       beat_cnt
);

  state_e           state_q, state_d;
  logic [31:0]      num_q, num_d;
  logic [31:0]      beat_cnt_q, beat_cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] p1_fold_q, p1_fold_d;
  logic             p1_v_q, p1_v_d;
  logic [SIG_W-1:0] fold;
  logic             accept;

  xor_folder #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W)
  ) u_xor_folder (
    .data_in (data_in),
    .fold    (fold)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    beat_cnt_d = beat_cnt_q;
    sig_d      = sig_q;
    accept     = (state_q == RUN) && data_valid && (beat_cnt_q < num_q);
    p1_v_d     = accept;
    p1_fold_d  = fold;

    if (p1_v_q) begin
      sig_d = misr_step(sig_q, p1_fold_q, POLY);
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d      = num_cycles;
          sig_d      = SEED;
          beat_cnt_d = '0;
          state_d    = (num_cycles == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 32'd1;
        end
        // Once the count is full no new beat can enter stage 1; the beat still
        // in p1 lands in the MISR on this same edge, so DONE follows directly.
        if ((beat_cnt_q == num_q) && !p1_v_d) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      beat_cnt_q <= '0;
      sig_q      <= SEED;
      p1_fold_q  <= '0;
      p1_v_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      beat_cnt_q <= beat_cnt_d;
      sig_q      <= sig_d;
      p1_fold_q  <= p1_fold_d;
      p1_v_q     <= p1_v_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign signature = sig_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_out_sig_compactor.sv
//==============================================================================
// Module      : tb_out_sig_compactor
// Description : Directed self-checking bench for out_sig_compactor.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_out_sig_compactor;

  localparam int          DATA_W = 330;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] SEED   = 32'hFFFFFFFF;

  logic              clk;
  logic              rst;
  logic              start;
  logic [31:0]       num_cycles;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic [31:0]       signature;
  logic [31:0]       beat_cnt;

  int total;
  int bad;

  out_sig_compactor #(
    .DATA_W (DATA_W),
    .SIG_W  (32),
    .POLY   (POLY),
    .SEED   (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_cycles (num_cycles),
    .data_valid (data_valid),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .beat_cnt   (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_fold(input logic [DATA_W-1:0] d);
    logic [351:0] p;
    logic [31:0]  r;
    p = '0;
    p[DATA_W-1:0] = d;
    r = '0;
    for (int k = 0; k < 11; k++) r = r ^ p[k*32 +: 32];
    return r;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start with an all-ones beat presented in the same cycle; it must not be taken.
  task automatic start_run(input logic [31:0] n);
    start      = 1'b1;
    num_cycles = n;
    data_valid = 1'b1;
    data_in    = '1;
    tick();
    start      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
  endtask

  task automatic beat(input logic v, input logic [DATA_W-1:0] d);
    data_valid = v;
    data_in    = d;
    tick();
    data_valid = 1'b0;
    data_in    = '0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, done}, 64'd1);
  endtask

  logic [DATA_W-1:0] d0, d1, d2;
  logic [31:0]       exp_sig;

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    start      = 1'b0;
    num_cycles = '0;
    data_valid = 1'b0;
    data_in    = '0;
    tick();
    tick();
    chk("rst_sig",  {32'd0, signature}, {32'd0, SEED});
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_cnt",  {32'd0, beat_cnt}, 64'd0);
    rst = 1'b0;
    tick();

    // num_cycles = 0 completes immediately
    start_run(32'd0);
    chk("n0_done", {63'd0, done}, 64'd1);
    chk("n0_busy", {63'd0, busy}, 64'd0);
    chk("n0_sig",  {32'd0, signature}, {32'd0, 32'hFFFFFFFF});
    chk("n0_cnt",  {32'd0, beat_cnt}, 64'd0);

    // Single zero beat, including pipeline latency
    start_run(32'd1);
    chk("n1_busy", {63'd0, busy}, 64'd1);
    beat(1'b1, '0);
    chk("n1_lat_sig",  {32'd0, signature}, {32'd0, SEED});
    chk("n1_lat_done", {63'd0, done}, 64'd0);
    tick();
    chk("n1_done", {63'd0, done}, 64'd1);
    chk("n1_sig",  {32'd0, signature}, {32'd0, 32'hFB3EE249});
    chk("n1_cnt",  {32'd0, beat_cnt}, 64'd1);

    // Fold cancellation and single-bit fold
    d0 = '0; d0[0] = 1'b1; d0[32] = 1'b1;
    start_run(32'd1);
    beat(1'b1, d0);
    wait_done("cancel_to", 10);
    chk("cancel_sig", {32'd0, signature}, {32'd0, 32'hFB3EE249});
    d0 = '0; d0[0] = 1'b1;
    start_run(32'd1);
    beat(1'b1, d0);
    wait_done("bit0_to", 10);
    chk("bit0_sig", {32'd0, signature}, {32'd0, 32'hFB3EE248});

    // Bubbles: pattern 1,0,0,1,1,0,1 with four beats wanted
    start_run(32'd4);
    begin
      logic [6:0] pat;
      pat = 7'b1011001;
      for (int i = 0; i < 7; i++) begin
        beat(pat[i], '0);
        if (i == 2) chk("bub_busy", {63'd0, busy}, 64'd1);
      end
    end
    wait_done("bub_to", 10);
    exp_sig = SEED;
    for (int i = 0; i < 4; i++) exp_sig = m_step(exp_sig, 32'h0);
    chk("bub_cnt", {32'd0, beat_cnt}, 64'd4);
    chk("bub_sig", {32'd0, signature}, {32'd0, exp_sig});

    // Excess beats ignored, start during RUN ignored
    d0 = '0; d0[5]   = 1'b1;
    d1 = '0; d1[40]  = 1'b1; d1[329] = 1'b1;
    d2 = '0; d2[100] = 1'b1;
    start_run(32'd2);
    beat(1'b1, d0);
    beat(1'b1, d1);
    start      = 1'b1;
    num_cycles = 32'd0;
    beat(1'b1, d2);
    start = 1'b0;
    beat(1'b1, d2);
    beat(1'b1, d2);
    exp_sig = m_step(m_step(SEED, m_fold(d0)), m_fold(d1));
    chk("ovr_done", {63'd0, done}, 64'd1);
    chk("ovr_cnt",  {32'd0, beat_cnt}, 64'd2);
    chk("ovr_sig",  {32'd0, signature}, {32'd0, exp_sig});
    tick();
    tick();
    chk("ovr_hold", {63'd0, done}, 64'd1);
    chk("ovr_hold_sig", {32'd0, signature}, {32'd0, exp_sig});

    // Restart from DONE, then reset mid-run
    start_run(32'd10);
    chk("rs_done_clr", {63'd0, done}, 64'd0);
    chk("rs_sig_seed", {32'd0, signature}, {32'd0, SEED});
    beat(1'b1, d0);
    beat(1'b1, d1);
    beat(1'b1, d2);
    chk("mid_cnt", {32'd0, beat_cnt}, 64'd3);
    rst = 1'b1;
    #2;
    chk("mid_async_busy", {63'd0, busy}, 64'd0);
    tick();
    rst = 1'b0;
    chk("mid_sig",  {32'd0, signature}, {32'd0, SEED});
    chk("mid_cnt0", {32'd0, beat_cnt}, 64'd0);
    chk("mid_done", {63'd0, done}, 64'd0);
    chk("mid_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("mid_idle", {63'd0, (busy | done)}, 64'd0);
    start_run(32'd1);
    beat(1'b1, '0);
    wait_done("post_to", 10);
    chk("post_sig", {32'd0, signature}, {32'd0, 32'hFB3EE249});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
